// File: rtl/pipeif_fetch.sv
// pipeif_fetch: IF stage owning the PC and IF/ID register, one-outstanding fetch to a variable-latency imem (option: PIPEIF_BACK2BACK_EN).
// Latency: a request issues in REQ; inst/dpc4 load on the edge where the response (or the held word) is accepted.
// Backpressure: we_pc_ir=0 holds PC and IF/ID; a word that returns during the stall is parked in the hold register.
module pipeif_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        we_pc_ir,
    input  logic        reset_ir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ra,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] dpc4,
    output logic [31:0] inst
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_KILL = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] pc_inc;
    logic [31:0] target;
    logic [31:0] hold_dat;
    logic [31:0] word_dat;
    logic        redirect;
    logic        accept;
    logic        word_avail;
    logic        hold_load;
    logic        b2b_issue;

    assign pc_inc     = pc + 32'd4;
    assign redirect   = we_pc_ir & (pcsource != 2'b00);
    assign accept     = we_pc_ir & ~reset_ir & ~redirect;
    assign word_avail = ((state == S_WAIT) & imem_valid) | (state == S_HOLD);
    assign word_dat   = (state == S_HOLD) ? hold_dat : imem_rdata;
    assign hold_load  = (state == S_WAIT) & ~we_pc_ir & imem_valid;

`ifdef PIPEIF_BACK2BACK_EN
    // Overlap the next fetch with the response being accepted; not from HOLD.
    assign b2b_issue = (state == S_WAIT) & accept & imem_valid;
`else
    assign b2b_issue = 1'b0;
`endif

    assign imem_req  = ((state == S_REQ) & ~redirect) | b2b_issue;
    assign imem_addr = b2b_issue ? pc_inc : pc;

    always_comb begin
        target = pc;
        case (pcsource)
            2'b01:   target = bpc;
            2'b10:   target = ra;
            2'b11:   target = jpc;
            default: target = pc;
        endcase
    end

    always_comb begin
        pc_nxt = pc;
        if (redirect)
            pc_nxt = target;
        else if (accept & word_avail)
            pc_nxt = pc_inc;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ:  state_nxt = redirect ? S_REQ : S_WAIT;
            S_WAIT: begin
                // A redirect with nothing back yet leaves a stale response in flight.
                if (redirect)
                    state_nxt = imem_valid ? S_REQ : S_KILL;
                else if (!we_pc_ir) begin
                    if (imem_valid)
                        state_nxt = S_HOLD;
                end else if (imem_valid)
                    state_nxt = b2b_issue ? S_WAIT : S_REQ;
            end
            S_HOLD: if (we_pc_ir) state_nxt = S_REQ;
            S_KILL: if (imem_valid) state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            hold_dat <= '0;
            inst     <= NOP_WORD;
            dpc4     <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (hold_load)
                hold_dat <= imem_rdata;
            if (we_pc_ir) begin
                if (accept & word_avail) begin
                    inst <= word_dat;
                    dpc4 <= pc_inc;
                end else begin
                    inst <= NOP_WORD;
                    dpc4 <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeif_fetch.sv
// Bench for pipeif_fetch: directed phases plus random traffic, checked against a transaction-level model
// that tracks only "request outstanding / stale / word buffered" and the architectural PC.
module tb_pipeif_fetch;

    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef PIPEIF_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        we_pc_ir = 1'b1;
    logic        reset_ir = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = '0;
    logic [31:0] jpc = '0;
    logic [31:0] ra = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_valid = 1'b0;
    logic [31:0] dpc4;
    logic [31:0] inst;

    always #5 clk = ~clk;

    pipeif_fetch dut (
        .clk        (clk),
        .clrn       (clrn),
        .we_pc_ir   (we_pc_ir),
        .reset_ir   (reset_ir),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .ra         (ra),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .dpc4       (dpc4),
        .inst       (inst)
    );

    int vectors = 0;
    int errors  = 0;

    // Memory: single pending response, latency lat cycles, returns addr ^ K.
    int          lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;

    // Reference model state.
    bit          m_started, m_out, m_stale, m_buf;
    logic [31:0] m_pc, m_inst, m_dpc4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_out = 0; m_stale = 0; m_buf = 0;
        m_pc = 32'h0; m_inst = NOP; m_dpc4 = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        imem_valid = 1'b0;
        model_reset();
        #1;
        check("rst_inst", inst, m_inst);
        check("rst_dpc4", dpc4, m_dpc4);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        @(posedge clk);
        #2 clrn = 1'b1;
    endtask

    task automatic cycle(input logic we, input logic rir, input logic [1:0] ps, input logic [31:0] tgt);
        logic        v, redir, acc, avail, b2b_exp, exp_req, resp;
        logic [31:0] exp_addr;
        @(negedge clk);
        we_pc_ir = we;
        reset_ir = rir;
        pcsource = ps;
        bpc = $urandom & 32'hFFFF_FFFC;
        jpc = $urandom & 32'hFFFF_FFFC;
        ra  = $urandom & 32'hFFFF_FFFC;
        case (ps)
            2'b01:   bpc = tgt;
            2'b10:   ra  = tgt;
            2'b11:   jpc = tgt;
            default: ;
        endcase
        v = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            v = (mem_cnt == 0);
        end
        imem_valid = v;
        imem_rdata = v ? (mem_addr ^ K) : $urandom;
        #1;
        redir    = we && (ps != 2'b00);
        acc      = we && !rir && !redir;
        avail    = (m_out && !m_stale && v) || m_buf;
        b2b_exp  = B2B && m_out && !m_stale && v && acc;
        exp_req  = (m_started && !m_out && !m_buf && !redir) || b2b_exp;
        exp_addr = b2b_exp ? m_pc + 32'd4 : m_pc;
        check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req)
            check("imem_addr", imem_addr, exp_addr);
        if (imem_req) begin
            mem_cnt  = lat;
            mem_addr = imem_addr;
        end
        @(posedge clk);
        #1;
        if (we) begin
            if (acc && avail) begin
                m_inst = m_pc ^ K;
                m_dpc4 = m_pc + 32'd4;
            end else begin
                m_inst = NOP;
                m_dpc4 = 32'h0;
            end
        end
        resp = m_out && v;
        if (resp) m_out = 0;
        if (resp && !we && !m_stale) m_buf = 1;
        else if (we) m_buf = 0;
        if (m_out && redir) m_stale = 1;
        if (!m_out) m_stale = 0;
        if (redir) m_pc = tgt;
        else if (acc && avail) m_pc = m_pc + 32'd4;
        if (exp_req) begin
            m_out = 1;
            m_stale = 0;
        end
        m_started = 1;
        check("inst", inst, m_inst);
        check("dpc4", dpc4, m_dpc4);
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 2'b00, 32'h0);
    endtask

    // Step sequentially until the memory holds exactly n cycles of remaining latency.
    task automatic run_until_cnt(input int n);
        int k;
        k = 0;
        while (mem_cnt != n && k < 40) begin
            cycle(1'b1, 1'b0, 2'b00, 32'h0);
            k++;
        end
        vectors++;
        assert (mem_cnt == n) else begin
            errors++;
            $error("FAIL wait_resp: pending %0d expected %0d", mem_cnt, n);
        end
    endtask

    initial begin
        logic        rwe, rrir;
        logic [1:0]  rps;

        // Reset and sequential fetch, L=1.
        model_reset();
        lat = 1;
        do_reset();
        seq(12);

        // Stall for three cycles while a word returns; flush/redirect inputs are ignored.
        run_until_cnt(1);
        cycle(1'b0, 1'b0, 2'b00, 32'h0);
        cycle(1'b0, 1'b1, 2'b01, 32'h0000_0200);
        cycle(1'b0, 1'b0, 2'b11, 32'h0000_0300);
        seq(6);

        // Redirect one cycle after a request, L=4: stale response is killed.
        lat = 4;
        run_until_cnt(4);
        cycle(1'b1, 1'b0, 2'b01, 32'h0000_0100);
        seq(16);

        // Redirect coincident with the response.
        run_until_cnt(1);
        cycle(1'b1, 1'b0, 2'b11, 32'h0000_0040);
        seq(10);

        // Flush while the word for 0x20 arrives: same PC is refetched.
        lat = 2;
        cycle(1'b1, 1'b0, 2'b10, 32'h0000_0020);
        run_until_cnt(1);
        cycle(1'b1, 1'b1, 2'b00, 32'h0);
        seq(8);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            lat  = $urandom_range(1, 4);
            rwe  = ($urandom_range(0, 9) < 8);
            rrir = ($urandom_range(0, 9) == 0);
            rps  = ($urandom_range(0, 9) < 8) ? 2'b00 : 2'($urandom_range(1, 3));
            cycle(rwe, rrir, rps, $urandom & 32'hFFFF_FFFC);
        end

        // Mid-run reset with a response possibly still pending, then PC wrap.
        lat = 2;
        seq(3);
        do_reset();
        lat = 1;
        seq(4);
        cycle(1'b1, 1'b0, 2'b01, 32'hFFFF_FFF4);
        seq(14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
